// File: rtl/key_event_ctrl.sv
// key_event_ctrl: debounced multi-key front end raising press/long/release events on a valid/ready port
module key_event_ctrl #(
    parameter int NUM_KEYS     = 4,
    parameter bit ACTIVE_LOW   = 1'b1,
    parameter int TICK_DIV     = 50000,
    parameter int STABLE_TICKS = 20,
    parameter int LONG_TICKS   = 1000
) (
    input  logic                                               clk,
    input  logic                                               rst,
    input  logic [NUM_KEYS-1:0]                                key_raw,
    output logic [NUM_KEYS-1:0]                                key_level,
    output logic                                               evt_valid,
    input  logic                                               evt_ready,
    output logic [(NUM_KEYS > 1 ? $clog2(NUM_KEYS) : 1)-1:0]   evt_key,
    output logic [1:0]                                         evt_type,
    input  logic                                               ovf_clr,
    output logic                                               overflow
);
    localparam int KW = NUM_KEYS > 1 ? $clog2(NUM_KEYS) : 1;
    localparam int PW = $clog2(TICK_DIV);
    localparam int SW = STABLE_TICKS > 1 ? $clog2(STABLE_TICKS) : 1;
    localparam int LW = $clog2(LONG_TICKS + 1);

    logic [NUM_KEYS-1:0] sync1, sync2;
    logic [PW-1:0]       pcnt;
    logic                tick;
    logic [SW-1:0]       cnt [NUM_KEYS];
    logic [LW-1:0]       lcnt [NUM_KEYS];
    logic [NUM_KEYS-1:0] fired;
    logic [NUM_KEYS-1:0] commit, set_p, set_l, set_r;
    logic [NUM_KEYS-1:0] pend_p, pend_l, pend_r;
    logic [NUM_KEYS-1:0] clr_p, clr_l, clr_r;
    logic [NUM_KEYS-1:0] any;
    logic [KW-1:0]       rr, grant, cand;
    logic [KW:0]         sum;
    logic                found, load, drop;
    logic [1:0]          gtype;

    assign tick = pcnt == PW'(TICK_DIV - 1);
    assign any  = pend_p | pend_l | pend_r;
    assign load = !evt_valid || evt_ready;
    assign drop = |((set_p & pend_p & ~clr_p) | (set_l & pend_l & ~clr_l) | (set_r & pend_r & ~clr_r));

    // two-flop synchroniser; polarity is folded in ahead of it so reset means "released"
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= key_raw ^ {NUM_KEYS{ACTIVE_LOW}};
            sync2 <= sync1;
        end
    end

    // shared free-running sample prescaler
    always_ff @(posedge clk) begin
        if (rst) pcnt <= '0;
        else     pcnt <= tick ? '0 : pcnt + 1'b1;
    end

    // per-key commit and event detection, only meaningful on tick cycles
    always_comb begin
        commit = '0;
        set_p  = '0;
        set_r  = '0;
        set_l  = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            commit[i] = tick && sync2[i] != key_level[i] && cnt[i] == SW'(STABLE_TICKS - 1);
            set_p[i]  = commit[i] && sync2[i];
            set_r[i]  = commit[i] && !sync2[i];
            set_l[i]  = tick && key_level[i] && !fired[i] && !commit[i] && lcnt[i] == LW'(LONG_TICKS - 1);
        end
    end

    // debounce counters, committed levels and long-press timers
    always_ff @(posedge clk) begin
        if (rst) begin
            key_level <= '0;
            fired     <= '0;
            for (int i = 0; i < NUM_KEYS; i++) begin
                cnt[i]  <= '0;
                lcnt[i] <= '0;
            end
        end else if (tick) begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                if (commit[i]) begin
                    key_level[i] <= sync2[i];
                    cnt[i]       <= '0;
                    lcnt[i]      <= '0;
                    if (!sync2[i]) fired[i] <= 1'b0;
                end else begin
                    cnt[i] <= sync2[i] != key_level[i] ? cnt[i] + 1'b1 : '0;
                    if (key_level[i] && !fired[i]) begin
                        lcnt[i]  <= lcnt[i] + 1'b1;
                        fired[i] <= set_l[i];
                    end
                end
            end
        end
    end

    // round-robin search for the first key with anything pending, starting at rr
    always_comb begin
        found = 1'b0;
        grant = '0;
        sum   = '0;
        cand  = '0;
        for (int k = 0; k < NUM_KEYS; k++) begin
            sum  = {1'b0, rr} + (KW+1)'(k);
            cand = sum >= (KW+1)'(NUM_KEYS) ? KW'(sum - (KW+1)'(NUM_KEYS)) : sum[KW-1:0];
            if (!found && any[cand]) begin
                found = 1'b1;
                grant = cand;
            end
        end
    end

    // event type of the granted key (press > long > release) and which flag the grant consumes
    always_comb begin
        clr_p = '0;
        clr_l = '0;
        clr_r = '0;
        gtype = 2'b00;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (grant == KW'(i)) begin
                gtype    = pend_p[i] ? 2'b00 : pend_l[i] ? 2'b10 : 2'b01;
                clr_p[i] = load && found && pend_p[i];
                clr_l[i] = load && found && !pend_p[i] && pend_l[i];
                clr_r[i] = load && found && !pend_p[i] && !pend_l[i] && pend_r[i];
            end
        end
    end

    // pending flags, sticky overflow and the event output register
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_p    <= '0;
            pend_l    <= '0;
            pend_r    <= '0;
            overflow  <= 1'b0;
            evt_valid <= 1'b0;
            evt_key   <= '0;
            evt_type  <= 2'b00;
            rr        <= '0;
        end else begin
            pend_p   <= set_p | (pend_p & ~clr_p);
            pend_l   <= set_l | (pend_l & ~clr_l);
            pend_r   <= set_r | (pend_r & ~clr_r);
            overflow <= drop || (overflow && !ovf_clr);
            if (load) begin
                evt_valid <= found;
                if (found) begin
                    evt_key  <= grant;
                    evt_type <= gtype;
                    rr       <= grant == KW'(NUM_KEYS - 1) ? '0 : grant + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_key_event_ctrl.sv
// tb_key_event_ctrl: directed checks of debounce, long-press, round-robin, overflow and reset behaviour
module tb_key_event_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] key_raw = 4'hF;
    logic [3:0] key_level;
    logic       evt_valid;
    logic       evt_ready = 1'b0;
    logic [1:0] evt_key, evt_type;
    logic       ovf_clr = 1'b0;
    logic       overflow;
    logic       seen;
    int         passed = 0, total = 0, n;

    key_event_ctrl #(
        .NUM_KEYS(4), .ACTIVE_LOW(1'b1), .TICK_DIV(4), .STABLE_TICKS(3), .LONG_TICKS(8)
    ) dut (
        .clk(clk), .rst(rst), .key_raw(key_raw), .key_level(key_level),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_key(evt_key), .evt_type(evt_type),
        .ovf_clr(ovf_clr), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic chk_evt(input string tag, input logic [1:0] k, input logic [1:0] t);
        chk(tag, {27'd0, evt_valid, evt_key, evt_type}, {27'd0, 1'b1, k, t});
    endtask

    task automatic consume();
        evt_ready = 1'b1;
        step();
        evt_ready = 1'b0;
    endtask

    task automatic wait_level(input int k, input logic v, output int c);
        c = 0;
        while (key_level[k] !== v && c < 60) begin
            step();
            c++;
        end
        chk($sformatf("level%0d_reach", k), {31'd0, key_level[k]}, {31'd0, v});
    endtask

    task automatic wait_evt(input int budget);
        int c = 0;
        while (evt_valid !== 1'b1 && c < budget) begin
            step();
            c++;
        end
        chk("evt_arrives", {31'd0, evt_valid}, 32'd1);
    endtask

    task automatic quiet(input int cycles, input string tag);
        logic s = 1'b0;
        repeat (cycles) begin
            step();
            s |= evt_valid;
        end
        chk(tag, {31'd0, s}, 32'd0);
    endtask

    initial begin
        // reset with all keys released
        repeat (3) step();
        chk("rst_level", {28'd0, key_level}, 32'd0);
        chk("rst_evt", {27'd0, evt_valid, evt_key, evt_type}, 32'd0);
        chk("rst_ovf", {31'd0, overflow}, 32'd0);
        rst = 1'b0;
        quiet(200, "idle_no_event");

        // bounce rejection on key 0, then a clean press
        seen = 1'b0;
        for (int r = 0; r < 5; r++) begin
            key_raw[0] = 1'b0;
            repeat (8) begin step(); seen |= evt_valid | key_level[0]; end
            key_raw[0] = 1'b1;
            repeat (4) begin step(); seen |= evt_valid | key_level[0]; end
        end
        chk("bounce_rejected", {31'd0, seen}, 32'd0);
        key_raw[0] = 1'b0;
        wait_level(0, 1'b1, n);
        chk("press_latency", {31'd0, n >= 11 && n <= 14}, 32'd1);
        chk("valid_lags_level", {31'd0, evt_valid}, 32'd0);
        step();
        chk_evt("press0", 2'd0, 2'b00);
        consume();
        chk("drained0", {31'd0, evt_valid}, 32'd0);
        key_raw[0] = 1'b1;
        wait_level(0, 1'b0, n);
        step();
        chk_evt("release0", 2'd0, 2'b01);
        consume();

        // simultaneous presses on keys 1 and 3 with the consumer stalled
        key_raw[1] = 1'b0;
        key_raw[3] = 1'b0;
        wait_evt(40);
        chk_evt("rr_first", 2'd1, 2'b00);
        seen = 1'b0;
        repeat (50) begin
            step();
            seen |= !(evt_valid && evt_key == 2'd1 && evt_type == 2'b00);
        end
        chk("rr_hold", {31'd0, seen}, 32'd0);
        consume();
        chk_evt("rr_second", 2'd3, 2'b00);
        evt_ready = 1'b1;
        step();
        chk_evt("rr_long1", 2'd1, 2'b10);
        step();
        chk_evt("rr_long3", 2'd3, 2'b10);
        step();
        chk("rr_drain", {31'd0, evt_valid}, 32'd0);
        key_raw[1] = 1'b1;
        key_raw[3] = 1'b1;
        wait_evt(40);
        chk_evt("rr_rel1", 2'd1, 2'b01);
        step();
        chk_evt("rr_rel3", 2'd3, 2'b01);
        step();
        chk("rr_drain2", {31'd0, evt_valid}, 32'd0);

        // pointer back at 0: key 0 wins over key 1
        key_raw[0] = 1'b0;
        key_raw[1] = 1'b0;
        wait_evt(40);
        chk_evt("ptr0_first", 2'd0, 2'b00);
        step();
        chk_evt("ptr0_second", 2'd1, 2'b00);
        key_raw[0] = 1'b1;
        key_raw[1] = 1'b1;
        step();
        chk("ptr0_drain", {31'd0, evt_valid}, 32'd0);
        wait_evt(40);
        chk_evt("ptr2_rel0", 2'd0, 2'b01);
        step();
        chk_evt("ptr2_rel1", 2'd1, 2'b01);

        // long press on key 2
        key_raw[2] = 1'b0;
        wait_level(2, 1'b1, n);
        step();
        chk_evt("press2", 2'd2, 2'b00);
        n = 1;
        do begin
            step();
            n++;
        end while (evt_valid !== 1'b1 && n < 60);
        chk("long_delay", n, 33);
        chk_evt("long2", 2'd2, 2'b10);
        quiet(47, "single_long");
        evt_ready = 1'b0;
        key_raw[2] = 1'b1;
        wait_level(2, 1'b0, n);
        step();
        chk_evt("release2", 2'd2, 2'b01);

        // overflow while the output is stalled on key 2's release
        key_raw[0] = 1'b0;
        wait_level(0, 1'b1, n);
        chk("ovf_pre1", {31'd0, overflow}, 32'd0);
        key_raw[0] = 1'b1;
        wait_level(0, 1'b0, n);
        chk("ovf_pre2", {31'd0, overflow}, 32'd0);
        ovf_clr = 1'b1;
        key_raw[0] = 1'b0;
        wait_level(0, 1'b1, n);
        chk("ovf_set_wins", {31'd0, overflow}, 32'd1);
        chk_evt("ovf_output_held", 2'd2, 2'b01);
        step();
        chk("ovf_cleared", {31'd0, overflow}, 32'd0);
        ovf_clr = 1'b0;
        consume();
        chk_evt("pend_press0", 2'd0, 2'b00);
        consume();
        chk_evt("pend_release0", 2'd0, 2'b01);
        consume();
        chk("pend_empty", {31'd0, evt_valid}, 32'd0);

        // reset while an event is held and two more are pending
        wait_evt(60);
        chk_evt("long0_held", 2'd0, 2'b10);
        key_raw[1] = 1'b0;
        wait_level(1, 1'b1, n);
        key_raw[1] = 1'b1;
        wait_level(1, 1'b0, n);
        chk_evt("held_before_rst", 2'd0, 2'b10);
        rst = 1'b1;
        step();
        chk("mid_rst_evt", {27'd0, evt_valid, evt_key, evt_type}, 32'd0);
        chk("mid_rst_level", {28'd0, key_level}, 32'd0);
        rst = 1'b0;
        wait_level(0, 1'b1, n);
        chk("repress_latency", n, 12);
        chk("repress_valid_lag", {31'd0, evt_valid}, 32'd0);
        step();
        chk_evt("repress0", 2'd0, 2'b00);
        consume();
        chk("repress_drain", {31'd0, evt_valid}, 32'd0);
        quiet(20, "lost_events");
        chk("final_levels", {28'd0, key_level}, 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
